uart_cfg_core: RTL and testbench

- Parametrised full-duplex UART core, successor to the fixed 8N1 loopback UART.
- Combines a shared baud/oversample tick generator, a transmitter and a receiver.
- Adds configurable data width, parity and stop bits, external serial pins, a runtime loopback select, and receive error and overrun status.
- Sits between the system bus logic and the board serial pins.

---
 rtl/uart_cfg_core.sv | 215 +++++++++++++++++++++
 tb/tb_uart_cfg_core.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_core.sv
// uart_cfg_core: parametrised full-duplex UART with a shared tick generator,
// configurable framing, runtime loopback and receive error/overrun status.
module uart_cfg_core #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wr_en,
    input  logic [DATA_BITS-1:0] i_din,
    output logic                 o_busy,
    output logic                 o_tx,
    input  logic                 i_rx,
    input  logic                 i_loopback,
    output logic                 o_rdy,
    input  logic                 i_rdy_clr,
    output logic [DATA_BITS-1:0] o_dout,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun
);
    localparam int RX_DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int RX_DIV     = (RX_DIV_RAW < 1) ? 1 : RX_DIV_RAW;
    localparam int DIV_W      = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
    localparam int OS_W       = $clog2(OVERSAMPLE);
    localparam int BIT_W      = $clog2(DATA_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(RX_DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    logic [DIV_W-1:0] r_div;
    logic [OS_W-1:0]  r_os;
    logic             w_rx_tick;
    logic             w_tx_tick;

    assign w_rx_tick = (r_div == DIV_LAST);
    assign w_tx_tick = w_rx_tick && (r_os == OS_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div <= '0;
            r_os  <= '0;
        end else begin
            r_div <= w_rx_tick ? '0 : r_div + 1'b1;
            if (w_rx_tick) r_os <= (r_os == OS_LAST) ? '0 : r_os + 1'b1;
        end
    end

    typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    tx_state_t            r_tx_state, w_tx_state;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift;
    logic [BIT_W-1:0]     r_tx_cnt, w_tx_cnt;
    logic                 r_tx_par, w_tx_par;
    logic                 r_tx_line, w_tx_line;

    always_comb begin
        w_tx_state = r_tx_state;
        w_tx_shift = r_tx_shift;
        w_tx_cnt   = r_tx_cnt;
        w_tx_par   = r_tx_par;
        case (r_tx_state)
            TX_IDLE: if (i_wr_en) begin
                w_tx_state = TX_WAIT;
                w_tx_shift = i_din;
                w_tx_par   = (^i_din) ^ PAR_ODD;
            end
            TX_WAIT: if (w_tx_tick) w_tx_state = TX_START;
            TX_START: if (w_tx_tick) begin
                w_tx_state = TX_DATA;
                w_tx_cnt   = '0;
            end
            TX_DATA: if (w_tx_tick) begin
                w_tx_shift = r_tx_shift >> 1;
                w_tx_cnt   = r_tx_cnt + 1'b1;
                if (r_tx_cnt == DATA_LAST) begin
                    w_tx_state = PAR_EN ? TX_PARITY : TX_STOP;
                    w_tx_cnt   = '0;
                end
            end
            TX_PARITY: if (w_tx_tick) w_tx_state = TX_STOP;
            TX_STOP: if (w_tx_tick) begin
                w_tx_cnt = r_tx_cnt + 1'b1;
                if (r_tx_cnt == STOP_LAST) w_tx_state = TX_IDLE;
            end
            default: w_tx_state = TX_IDLE;
        endcase
    end

    // Line level is registered so the pin never sees decode glitches.
    assign w_tx_line = (r_tx_state == TX_START)  ? 1'b0 :
                       (r_tx_state == TX_DATA)   ? r_tx_shift[0] :
                       (r_tx_state == TX_PARITY) ? r_tx_par : 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
            r_tx_par   <= 1'b0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state;
            r_tx_shift <= w_tx_shift;
            r_tx_cnt   <= w_tx_cnt;
            r_tx_par   <= w_tx_par;
            r_tx_line  <= w_tx_line;
        end
    end

    assign o_busy = (r_tx_state != TX_IDLE);
    assign o_tx   = i_loopback | r_tx_line;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    logic [1:0]           r_sync;
    logic                 w_line;
    logic                 w_centre;
    logic                 w_done;
    rx_state_t            r_rx_state, w_rx_state;
    logic [OS_W-1:0]      r_rx_os, w_rx_os;
    logic [BIT_W-1:0]     r_rx_cnt, w_rx_cnt;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift;
    logic                 r_par_bad, w_par_bad;
    logic                 r_rdy, r_ferr, r_perr, r_ovr;
    logic [DATA_BITS-1:0] r_dout;

    assign w_line   = r_sync[1];
    assign w_centre = (r_rx_os == OS_LAST);

    always_comb begin
        w_rx_state = r_rx_state;
        w_rx_os    = r_rx_os;
        w_rx_cnt   = r_rx_cnt;
        w_rx_shift = r_rx_shift;
        w_par_bad  = r_par_bad;
        w_done     = 1'b0;
        if (w_rx_tick) begin
            w_rx_os = w_centre ? '0 : r_rx_os + 1'b1;
            case (r_rx_state)
                RX_IDLE: begin
                    w_rx_os = '0;
                    if (!w_line) w_rx_state = RX_START;
                end
                RX_START: if (r_rx_os == OS_HALF) begin
                    w_rx_os    = '0;
                    w_rx_cnt   = '0;
                    w_rx_state = w_line ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (w_centre) begin
                    w_rx_shift = {w_line, r_rx_shift[DATA_BITS-1:1]};
                    w_rx_cnt   = r_rx_cnt + 1'b1;
                    if (r_rx_cnt == DATA_LAST) w_rx_state = PAR_EN ? RX_PARITY : RX_STOP;
                end
                RX_PARITY: if (w_centre) begin
                    w_par_bad  = w_line ^ (^r_rx_shift) ^ PAR_ODD;
                    w_rx_state = RX_STOP;
                end
                RX_STOP: if (w_centre) begin
                    w_done     = 1'b1;
                    w_rx_state = RX_IDLE;
                end
                default: w_rx_state = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync     <= 2'b11;
            r_rx_state <= RX_IDLE;
            r_rx_os    <= '0;
            r_rx_cnt   <= '0;
            r_rx_shift <= '0;
            r_par_bad  <= 1'b0;
            r_rdy      <= 1'b0;
            r_dout     <= '0;
            r_ferr     <= 1'b0;
            r_perr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], i_loopback ? r_tx_line : i_rx};
            r_rx_state <= w_rx_state;
            r_rx_os    <= w_rx_os;
            r_rx_cnt   <= w_rx_cnt;
            r_rx_shift <= w_rx_shift;
            r_par_bad  <= w_par_bad;
            if (w_done) begin
                r_rdy  <= 1'b1;
                r_dout <= r_rx_shift;
                r_ferr <= !w_line;
                r_perr <= PAR_EN & r_par_bad;
                r_ovr  <= r_rdy & !i_rdy_clr;
            end else if (i_rdy_clr) begin
                r_rdy  <= 1'b0;
                r_ferr <= 1'b0;
                r_perr <= 1'b0;
                r_ovr  <= 1'b0;
            end
        end
    end

    assign o_rdy        = r_rdy;
    assign o_dout       = r_dout;
    assign o_frame_err  = r_ferr;
    assign o_parity_err = r_perr;
    assign o_overrun    = r_ovr;
endmodule

// File: tb/tb_uart_cfg_core.sv
// tb_uart_cfg_core: scoreboard bench for uart_cfg_core with 8N1, even-parity
// and 9-bit/2-stop instances sharing clock, reset, rx pin and rdy_clr.
module tb_uart_cfg_core;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx_drv = 1'b1;
    logic ext_loop = 1'b0;
    logic loopback = 1'b0;
    logic rdy_clr = 1'b0;
    logic wr_a = 1'b0;
    logic wr_c = 1'b0;
    logic [8:0] din = '0;
    logic rx_line;
    logic busy_a, tx_a, rdy_a, fe_a, pe_a, ov_a;
    logic busy_b, tx_b, rdy_b, fe_b, pe_b, ov_b;
    logic busy_c, tx_c, rdy_c, fe_c, pe_c, ov_c;
    logic [7:0] dout_a, dout_b;
    logic [8:0] dout_c;
    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {logic [8:0] dout; logic fe; logic pe; logic ov;} exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    assign rx_line = ext_loop ? tx_a : rx_drv;

    uart_cfg_core #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16)) u_a (
        .i_clk(clk), .i_reset(reset), .i_wr_en(wr_a), .i_din(din[7:0]), .o_busy(busy_a),
        .o_tx(tx_a), .i_rx(rx_line), .i_loopback(loopback), .o_rdy(rdy_a), .i_rdy_clr(rdy_clr),
        .o_dout(dout_a), .o_frame_err(fe_a), .o_parity_err(pe_a), .o_overrun(ov_a));

    uart_cfg_core #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .PARITY_EN(1)) u_b (
        .i_clk(clk), .i_reset(reset), .i_wr_en(1'b0), .i_din(din[7:0]), .o_busy(busy_b),
        .o_tx(tx_b), .i_rx(rx_line), .i_loopback(loopback), .o_rdy(rdy_b), .i_rdy_clr(rdy_clr),
        .o_dout(dout_b), .o_frame_err(fe_b), .o_parity_err(pe_b), .o_overrun(ov_b));

    uart_cfg_core #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVERSAMPLE(16), .DATA_BITS(9),
                    .STOP_BITS(2)) u_c (
        .i_clk(clk), .i_reset(reset), .i_wr_en(wr_c), .i_din(din), .o_busy(busy_c),
        .o_tx(tx_c), .i_rx(rx_line), .i_loopback(loopback), .o_rdy(rdy_c), .i_rdy_clr(rdy_clr),
        .o_dout(dout_c), .o_frame_err(fe_c), .o_parity_err(pe_c), .o_overrun(ov_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic rdy_of(input int i);
        return (i == 0) ? rdy_a : (i == 1) ? rdy_b : rdy_c;
    endfunction

    function automatic exp_t obs(input int i);
        exp_t o;
        if (i == 0) o = {{1'b0, dout_a}, fe_a, pe_a, ov_a};
        else if (i == 1) o = {{1'b0, dout_b}, fe_b, pe_b, ov_b};
        else o = {dout_c, fe_c, pe_c, ov_c};
        return o;
    endfunction

    task automatic push(input logic [8:0] d, input logic fe, input logic pe, input logic ov);
        exp_t e;
        e = {d, fe, pe, ov};
        sb.push_back(e);
    endtask

    task automatic check_frame(input string tag, input int inst);
        exp_t e;
        exp_t o;
        int n = 0;
        while (!rdy_of(inst) && n < 300) begin
            tick(1);
            n++;
        end
        check({tag, "_rdy"}, rdy_of(inst), 1);
        check({tag, "_sb"}, 32'(sb.size() > 0), 1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        o = obs(inst);
        check({tag, "_dout"}, o.dout, e.dout);
        check({tag, "_ferr"}, o.fe, e.fe);
        check({tag, "_perr"}, o.pe, e.pe);
        check({tag, "_ovr"}, o.ov, e.ov);
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        tick(1);
        rdy_clr = 1'b0;
        tick(1);
    endtask

    task automatic rx_frame(input logic [8:0] d, input bit par, input logic pbit, input logic sbit);
        rx_drv = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            tick(16);
        end
        if (par) begin
            rx_drv = pbit;
            tick(16);
        end
        rx_drv = sbit;
        tick(16);
        rx_drv = 1'b1;
        tick(16);
    endtask

    task automatic wait_idle(input int inst, output int n, output logic saw_low);
        n = 0;
        saw_low = 1'b0;
        while ((inst == 0 ? busy_a : busy_c) && n < 1000) begin
            n++;
            saw_low |= !(inst == 0 ? tx_a : tx_c);
            tick(1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end

    initial begin
        int n;
        logic low;
        exp_t o;
        tick(3);
        reset = 1'b0;
        o = obs(0);
        check("rst_tx", tx_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_rdy", rdy_a, 0);
        check("rst_dout", o.dout, 0);
        check("rst_ferr", o.fe, 0);
        check("rst_perr", o.pe, 0);
        check("rst_ovr", o.ov, 0);

        loopback = 1'b1;
        tick(2);
        push(9'h0A5, 0, 0, 0);
        din = 9'h0A5;
        wr_a = 1'b1;
        tick(1);
        wr_a = 1'b0;
        wait_idle(0, n, low);
        check("t1_busy_len", 32'(n >= 161 && n <= 176), 1);
        check("t1_tx_pin", low, 0);
        check_frame("t1", 0);

        loopback = 1'b0;
        tick(2);
        pulse_clr();
        push(9'h03C, 0, 0, 0);
        rx_frame(9'h03C, 1, 1'b0, 1'b1);
        check_frame("t2a", 1);
        pulse_clr();
        push(9'h03C, 0, 1, 0);
        rx_frame(9'h03C, 1, 1'b1, 1'b1);
        check_frame("t2b", 1);
        tick(40);

        pulse_clr();
        push(9'h055, 1, 0, 0);
        rx_frame(9'h055, 0, 1'b0, 1'b0);
        check_frame("t3a", 0);
        tick(200);
        pulse_clr();
        push(9'h0C3, 0, 0, 0);
        rx_frame(9'h0C3, 0, 1'b0, 1'b1);
        check_frame("t3b", 0);

        pulse_clr();
        push(9'h011, 0, 0, 0);
        rx_frame(9'h011, 0, 1'b0, 1'b1);
        check_frame("t4a", 0);
        push(9'h022, 0, 0, 1);
        rx_frame(9'h022, 0, 1'b0, 1'b1);
        check_frame("t4b", 0);
        pulse_clr();
        o = obs(0);
        check("t4_clr_rdy", rdy_a, 0);
        check("t4_clr_ovr", o.ov, 0);
        check("t4_clr_ferr", o.fe, 0);
        check("t4_clr_perr", o.pe, 0);

        rx_drv = 1'b0;
        tick(4);
        rx_drv = 1'b1;
        tick(40);
        o = obs(0);
        check("t5_glitch_rdy", rdy_a, 0);
        check("t5_glitch_ferr", o.fe, 0);
        check("t5_glitch_dout", o.dout, 9'h022);
        push(9'h07E, 0, 0, 0);
        rx_frame(9'h07E, 0, 1'b0, 1'b1);
        check_frame("t5", 0);
        pulse_clr();

        loopback = 1'b1;
        tick(2);
        push(9'h0F0, 0, 0, 0);
        din = 9'h0F0;
        wr_a = 1'b1;
        tick(1);
        wr_a = 1'b0;
        tick(20);
        din = 9'h00F;
        wr_a = 1'b1;
        tick(1);
        wr_a = 1'b0;
        wait_idle(0, n, low);
        check("t6a_idle", busy_a, 0);
        check_frame("t6a", 0);
        pulse_clr();
        tick(250);
        check("t6a_single", rdy_a, 0);

        loopback = 1'b0;
        ext_loop = 1'b1;
        tick(2);
        din = 9'h000;
        wr_a = 1'b1;
        tick(1);
        wr_a = 1'b0;
        tick(60);
        check("t6b_busy_mid", busy_a, 1);
        check("t6b_tx_mid", tx_a, 0);
        reset = 1'b1;
        tick(1);
        check("t6b_rst_tx", tx_a, 1);
        check("t6b_rst_busy", busy_a, 0);
        reset = 1'b0;
        tick(250);
        check("t6b_no_rdy", rdy_a, 0);
        ext_loop = 1'b0;

        loopback = 1'b1;
        tick(2);
        push(9'h1AB, 0, 0, 0);
        din = 9'h1AB;
        wr_c = 1'b1;
        tick(1);
        wr_c = 1'b0;
        wait_idle(2, n, low);
        check("t6c_busy_len", 32'(n >= 193 && n <= 208), 1);
        check_frame("t6c", 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
